// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory-side responder for the dcache refill/writeback port.
// It takes one read or write request at a time and performs it on a synchronous
// single-port SRAM. Read beats return one cycle after each SRAM read access.
// Optional build macro RESP_DELAY_EN inserts RESP_DELAY idle cycles before the
// first SRAM access of every request.
// SRAM_AW must be at most 29 so that the word address fits inside a 32-bit byte address.
module cache_mem_responder #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SRAM_AW    = 16,
  parameter int unsigned RESP_DELAY = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_req,
  input  logic [2:0]                 rd_type,
  input  logic [31:0]                rd_addr,
  output logic                       rd_rdy,
  output logic                       ret_valid,
  output logic                       ret_last,
  output logic [31:0]                ret_data,
  input  logic                       wr_req,
  input  logic [2:0]                 wr_type,
  input  logic [31:0]                wr_addr,
  input  logic [3:0]                 wr_wstrb,
  input  logic [LINE_WORDS*32-1:0]   wr_data,
  output logic                       wr_rdy,
  output logic                       sram_en,
  output logic [3:0]                 sram_we,
  output logic [SRAM_AW-1:0]         sram_addr,
  output logic [31:0]                sram_wdata,
  input  logic [31:0]                sram_rdata
);

  localparam int unsigned CW      = $clog2(LINE_WORDS);
  localparam int unsigned STATE_W = 3;
  localparam logic [2:0]  TYPE_LINE = 3'b100;
  localparam logic [SRAM_AW-1:0] LINE_MASK = ~SRAM_AW'(LINE_WORDS - 1);

`ifdef RESP_DELAY_EN
  localparam bit          DELAY_ON = (RESP_DELAY != 0);
  localparam int unsigned WW       = (RESP_DELAY < 2) ? 1 : $clog2(RESP_DELAY);
`else
  localparam bit          DELAY_ON = 1'b0;
  localparam int unsigned unused_resp_delay = RESP_DELAY;
`endif

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_RETURN
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic                           r_live;
  logic                           r_line;
  logic [SRAM_AW-1:0]             r_addr;
  logic [LINE_WORDS-1:0][31:0]    r_wdata;
  logic [3:0]                     r_wstrb;
  logic [CW-1:0]                  r_cnt;
  logic                           r_ret_valid;
  logic                           r_ret_last;

  logic                           w_accept_wr;
  logic                           w_accept_rd;
  logic                           w_last_beat;
  logic [SRAM_AW-1:0]             w_beat_addr;
  logic [SRAM_AW-1:0]             w_rd_word;
  logic [SRAM_AW-1:0]             w_wr_word;
  logic                           w_unused_addr_bits;

  assign w_accept_wr = wr_req & wr_rdy;
  assign w_accept_rd = rd_req & rd_rdy;
  assign w_last_beat = !r_line || (r_cnt == CW'(LINE_WORDS - 1));
  assign w_beat_addr = r_addr + SRAM_AW'(r_cnt);
  assign w_rd_word   = rd_addr[SRAM_AW+1:2];
  assign w_wr_word   = wr_addr[SRAM_AW+1:2];

  // Byte-offset and high address bits never reach the SRAM.
  assign w_unused_addr_bits = ^{rd_addr[31:SRAM_AW+2], rd_addr[1:0],
                                wr_addr[31:SRAM_AW+2], wr_addr[1:0]};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a write wins over a simultaneous read.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept_wr)      w_state_nxt = DELAY_ON ? S_WAIT : S_WRITE;
        else if (w_accept_rd) w_state_nxt = DELAY_ON ? S_WAIT : S_RD_ISSUE;
      end
      S_WAIT: begin
`ifdef RESP_DELAY_EN
        if (r_wait_cnt == WW'(RESP_DELAY - 1))
          w_state_nxt = r_is_wr ? S_WRITE : S_RD_ISSUE;
`else
        w_state_nxt = S_IDLE;
`endif
      end
      S_WRITE:     if (w_last_beat) w_state_nxt = S_IDLE;
      S_RD_ISSUE:  if (w_last_beat) w_state_nxt = S_RD_RETURN;
      S_RD_RETURN: w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from state and latched request.
  always_comb begin
    rd_rdy     = 1'b0;
    wr_rdy     = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 4'h0;
    sram_addr  = '0;
    sram_wdata = 32'h0;
    case (r_state)
      S_IDLE: begin
        wr_rdy = r_live;
        rd_rdy = r_live & ~wr_req;
      end
      S_WRITE: begin
        sram_en    = 1'b1;
        sram_we    = r_line ? 4'hF : r_wstrb;
        sram_addr  = w_beat_addr;
        sram_wdata = r_wdata[r_cnt];
      end
      S_RD_ISSUE: begin
        sram_en   = 1'b1;
        sram_addr = w_beat_addr;
      end
      default: ;
    endcase
  end

  // Request latch, beat counter and read-return pipeline stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live      <= 1'b0;
      r_line      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= 4'h0;
      r_cnt       <= '0;
      r_ret_valid <= 1'b0;
      r_ret_last  <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      r_ret_valid <= (r_state == S_RD_ISSUE);
      r_ret_last  <= (r_state == S_RD_ISSUE) && w_last_beat;
      if (w_accept_wr) begin
        r_line  <= (wr_type == TYPE_LINE);
        r_addr  <= (wr_type == TYPE_LINE) ? (w_wr_word & LINE_MASK) : w_wr_word;
        r_wdata <= wr_data;
        r_wstrb <= wr_wstrb;
        r_cnt   <= '0;
      end else if (w_accept_rd) begin
        r_line <= (rd_type == TYPE_LINE);
        r_addr <= (rd_type == TYPE_LINE) ? (w_rd_word & LINE_MASK) : w_rd_word;
        r_cnt  <= '0;
      end else if (r_state == S_WRITE || r_state == S_RD_ISSUE) begin
        r_cnt <= w_last_beat ? '0 : r_cnt + CW'(1);
      end
    end
  end

`ifdef RESP_DELAY_EN
  logic [WW-1:0] r_wait_cnt;
  logic          r_is_wr;

  // Idle-cycle counter and request direction for the WAIT state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
      r_is_wr    <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + WW'(1) : '0;
      if (w_accept_wr)      r_is_wr <= 1'b1;
      else if (w_accept_rd) r_is_wr <= 1'b0;
    end
  end
`endif

  assign ret_valid = r_ret_valid;
  assign ret_last  = r_ret_last;
  assign ret_data  = r_ret_valid ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder with a behavioural SRAM and a shadow memory
// model; expected read beats are queued when a read is driven and popped per beat.
module tb_cache_mem_responder;

  localparam int unsigned LW  = 4;
  localparam int unsigned AW  = 16;
  localparam int unsigned DLY = 3;
`ifdef RESP_DELAY_EN
  localparam int LAT = DLY + 2;
`else
  localparam int LAT = 2;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 rd_req;
  logic [2:0]           rd_type;
  logic [31:0]          rd_addr;
  logic                 rd_rdy;
  logic                 ret_valid;
  logic                 ret_last;
  logic [31:0]          ret_data;
  logic                 wr_req;
  logic [2:0]           wr_type;
  logic [31:0]          wr_addr;
  logic [3:0]           wr_wstrb;
  logic [LW*32-1:0]     wr_data;
  logic                 wr_rdy;
  logic                 sram_en;
  logic [3:0]           sram_we;
  logic [AW-1:0]        sram_addr;
  logic [31:0]          sram_wdata;
  logic [31:0]          sram_rdata;

  logic [31:0]          mem    [0:(1<<AW)-1];
  logic [31:0]          shadow [0:(1<<AW)-1];
  logic                 bd_we;
  logic [AW-1:0]        bd_addr;
  logic [31:0]          bd_data;
  logic [32:0]          exp_q [$];
  int                   n_cmp;
  int                   n_err;

  cache_mem_responder #(.LINE_WORDS(LW), .SRAM_AW(AW), .RESP_DELAY(DLY)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port SRAM with a backdoor preload port.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (sram_en) begin
      if (sram_we == 4'h0) sram_rdata <= mem[sram_addr];
      else for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    shadow[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic read_req(input logic [2:0] typ, input logic [31:0] addr);
    int            n;
    logic [AW-1:0] base;
    logic [32:0]   e;
    n    = (typ == 3'b100) ? LW : 1;
    base = addr[AW+1:2];
    if (typ == 3'b100) base = base & ~AW'(LW - 1);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), shadow[base + AW'(i)]});
    rd_req = 1'b1; rd_type = typ; rd_addr = addr;
    #1;
    check("rd_accept", 64'(rd_rdy), 64'(1));
    @(negedge clk);
    rd_req = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      check("rd_wait_valid", 64'(ret_valid), 64'(0));
      check("rd_wait_rdy", 64'(rd_rdy), 64'(0));
      check("rd_issue_en", 64'(sram_en), 64'(c == LAT - 1));
      if (c == LAT - 1) check("rd_issue_addr", 64'(sram_addr), 64'(base));
      @(negedge clk);
    end
    for (int b = 0; b < n; b++) begin
      e = exp_q.pop_front();
      check("beat_valid", 64'(ret_valid), 64'(1));
      check("beat_data", 64'(ret_data), 64'(e[31:0]));
      check("beat_last", 64'(ret_last), 64'(e[32]));
      @(negedge clk);
    end
    check("beat_after_valid", 64'(ret_valid), 64'(0));
    check("rd_rdy_after", 64'(rd_rdy), 64'(1));
  endtask

  task automatic write_req(input logic [2:0] typ, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [LW*32-1:0] data);
    int            n;
    logic [AW-1:0] base;
    logic [31:0]   w;
    n    = (typ == 3'b100) ? LW : 1;
    base = addr[AW+1:2];
    if (typ == 3'b100) base = base & ~AW'(LW - 1);
    wr_req = 1'b1; wr_type = typ; wr_addr = addr; wr_wstrb = strb; wr_data = data;
    #1;
    check("wr_accept", 64'(wr_rdy), 64'(1));
    check("rd_blocked_by_wr", 64'(rd_rdy), 64'(0));
    @(negedge clk);
    wr_req = 1'b0;
    for (int c = 1; c < LAT - 1; c++) begin
      check("wr_wait_en", 64'(sram_en), 64'(0));
      check("wr_wait_rdy", 64'({wr_rdy, rd_rdy}), 64'(0));
      @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      w = data[32*i +: 32];
      check("wr_en", 64'(sram_en), 64'(1));
      check("wr_we", 64'(sram_we), 64'((n == 1) ? strb : 4'hF));
      check("wr_addr", 64'(sram_addr), 64'(base + AW'(i)));
      check("wr_wdata", 64'(sram_wdata), 64'(w));
      check("wr_busy_rdy", 64'({wr_rdy, rd_rdy}), 64'(0));
      if (n == 1) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) shadow[base][8*b +: 8] = w[8*b +: 8];
      end else begin
        shadow[base + AW'(i)] = w;
      end
      @(negedge clk);
    end
    check("wr_rdy_after", 64'(wr_rdy), 64'(1));
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b0;
    rd_req = 1'b0; rd_type = 3'b000; rd_addr = 32'h0;
    wr_req = 1'b0; wr_type = 3'b000; wr_addr = 32'h0; wr_wstrb = 4'h0; wr_data = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = 32'h0;
    #1;
    check("reset_rdy", 64'({rd_rdy, wr_rdy}), 64'(0));
    check("reset_ret", 64'({ret_valid, ret_last, ret_data}), 64'(0));
    check("reset_sram", 64'({sram_en, sram_we, sram_addr}), 64'(0));
    check("reset_wdata", 64'(sram_wdata), 64'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Refill line read from an unaligned address inside the line.
    preload(16'h0040, 32'h11111111);
    preload(16'h0041, 32'h22222222);
    preload(16'h0042, 32'h33333333);
    preload(16'h0043, 32'h44444444);
    read_req(3'b100, 32'h0000_0108);

    // Single-word read.
    preload(16'h0041, 32'hDEADBEEF);
    read_req(3'b010, 32'h0000_0104);

    // Byte write with one strobe, then word read of the merged word.
    preload(16'h0080, 32'h12345678);
    write_req(3'b000, 32'h0000_0202, 4'b0100, {96'h0, 32'h00AB0000});
    read_req(3'b010, 32'h0000_0200);
    check("byte_merge_model", 64'(shadow[16'h0080]), 64'(32'h12AB5678));

    // Half read and an undefined type both act as a single-word access.
    read_req(3'b001, 32'h0000_010E);
    read_req(3'b111, 32'h0000_0100);

    // Victim writeback and refill raised together: write first, then the read.
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_0300;
    write_req(3'b100, 32'h0000_0300, 4'hF, {32'd4, 32'd3, 32'd2, 32'd1});
    read_req(3'b100, 32'h0000_0300);

    // Reset asserted during the second beat of a line read.
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_0108;
    #1;
    check("rst_rd_accept", 64'(rd_rdy), 64'(1));
    @(negedge clk);
    rd_req = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check("rst_beat1", 64'({ret_valid, ret_data}), 64'({1'b1, 32'h11111111}));
    @(negedge clk);
    check("rst_beat2_valid", 64'(ret_valid), 64'(1));
    reset = 1'b0;
    #1;
    check("rst_ret_drop", 64'({ret_valid, ret_last, ret_data}), 64'(0));
    check("rst_sram_drop", 64'({sram_en, sram_we}), 64'(0));
    check("rst_rdy_drop", 64'({rd_rdy, wr_rdy}), 64'(0));
    @(negedge clk);
    check("rst_hold", 64'({ret_valid, sram_en}), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check("rst_release_rdy", 64'(rd_rdy), 64'(1));
    for (int c = 0; c < 6; c++) begin
      check("rst_no_stray", 64'({ret_valid, sram_en}), 64'(0));
      @(negedge clk);
    end
    read_req(3'b010, 32'h0000_010C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Memory-side responder for the data cache's refill/writeback port.
- Accepts one request at a time on the cache's rd_req/rd_rdy and wr_req/wr_rdy handshakes, and performs it on a synchronous single-port SRAM.
- Read data returns to the cache as ret_valid/ret_data beats, with ret_last on the final beat.
- Sits between the dcache miss/writeback logic and the data memory model used in simulation and FPGA bring-up.

Parameters:
- LINE_WORDS, 4: words per cache line; power of two, at least 2.
- SRAM_AW, 16: SRAM word-address width; the SRAM word address is addr[SRAM_AW+1:2].
- RESP_DELAY, 3: extra idle cycles before the first SRAM access. Used only with RESP_DELAY_EN.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request valid.
- rd_type  in  3  read type: 3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 cache line.
- rd_addr  in  32  read byte address.
- rd_rdy  out  1  read request accepted this cycle when rd_req is also high.
- ret_valid  out  1  read data beat valid.
- ret_last  out  1  final beat of the current read.
- ret_data  out  32  read data beat.
- wr_req  in  1  write request valid.
- wr_type  in  3  write type; same encoding as rd_type.
- wr_addr  in  32  write byte address.
- wr_wstrb  in  4  byte strobes; used for non-line writes only.
- wr_data  in  LINE_WORDS*32  write data; word i is bits [32i+31:32i].
- wr_rdy  out  1  write request accepted this cycle when wr_req is also high.
- sram_en  out  1  SRAM access enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  SRAM_AW  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data; valid the cycle after a read access.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, beat counter 0. rd_rdy=0, wr_rdy=0, ret_valid=0, ret_last=0, ret_data=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
- IDLE: rd_rdy=1 and wr_rdy=1, except that rd_rdy=0 whenever wr_req=1. Write wins simultaneous requests, so a victim writeback lands before the refill read.
  - Accepted request: latch type, address and data (for writes, also strobes). Ready outputs drop on the next cycle.
  - Both ready outputs stay 0 outside IDLE.
- Address forming:
  - Line request: base word = addr word with its low log2(LINE_WORDS) bits cleared; beats go base+0 upward to base+LINE_WORDS-1, with no wrap.
  - Non-line request: one access to addr[SRAM_AW+1:2]. Byte offset bits are ignored; the cache extracts bytes and halves.
- WRITE (line):
  - LINE_WORDS consecutive cycles with sram_en=1, sram_we=4'hF, sram_wdata = latched word i, one word per cycle.
  - Then IDLE; wr_rdy is high again the cycle after the last write.
- WRITE (non-line): one cycle with sram_en=1, sram_we=latched wr_wstrb, sram_wdata=word 0; then IDLE.
- RD_ISSUE: one read access per cycle (sram_en=1, sram_we=0); LINE_WORDS accesses for a line, 1 otherwise.
- RD_RETURN (pipelined with RD_ISSUE): each access produces ret_valid=1 and ret_data=sram_rdata exactly one cycle later.
  - Beats arrive on consecutive cycles.
  - ret_last=1 only with the final beat; a single-word read has ret_valid=1 and ret_last=1 together.
  - Read latency is acceptance to first beat = 2 cycles.
  - After the last beat: IDLE; ret_valid=0 next cycle.
- No back-pressure on ret_*; the cache must accept every beat.
- rd_type/wr_type values other than 000/001/010/100 are treated as a word access.
- Reset mid-transaction: the transaction is discarded, no further SRAM writes occur, and outputs go to reset values immediately.

Optional Feature:
- Macro RESP_DELAY_EN.
- Defined: after acceptance, a WAIT state holds for RESP_DELAY cycles with sram_en=0 before the first SRAM access. Read latency becomes RESP_DELAY+2 cycles. Ready outputs stay 0 during WAIT. Used to stress dcache miss handling.
- Undefined: no WAIT state; the RESP_DELAY parameter is ignored.

Test Plan:
- Preload SRAM words 0x40..0x43 with 0x11111111,0x22222222,0x33333333,0x44444444; rd_type=100, rd_addr=0x0000_0108 -> beats 0x11111111,0x22222222,0x33333333,0x44444444 on 4 consecutive cycles starting 2 cycles after acceptance; ret_last only on 0x44444444.
- rd_type=010, rd_addr=0x0000_0104, word 0x41=0xDEADBEEF -> single beat 0xDEADBEEF with ret_valid=ret_last=1 at cycle 2; rd_rdy high again in the following cycle.
- wr_type=000, wr_addr=0x0000_0202, wr_wstrb=4'b0100, wr_data[31:0]=0x00AB0000 over word 0x80=0x12345678 -> later word read returns 0x12AB5678.
- Same-cycle wr_req (line, addr 0x300, data words 1,2,3,4) and rd_req (line, addr 0x300) -> rd_rdy=0 while the write runs; 4 SRAM writes complete first; the read then returns 1,2,3,4.
- Assert reset low during beat 2 of a line read -> ret_valid and sram_en drop immediately. After release: rd_rdy=1, no stray beats.
- With RESP_DELAY_EN and RESP_DELAY=3, word read -> first beat 5 cycles after acceptance; sram_en=0 for the 3 WAIT cycles.
